sa_act_skew: RTL and testbench
==============================

Name: sa_act_skew

Overview:
- Input-activation skew stage that sits directly upstream of the weight-stationary compute array.
- Accepts one unskewed activation vector (one element per array row) per cycle through a valid/ready handshake.
- Delays row r by r cycles, so the array receives the diagonal wavefront it expects on i_act.
- Sequences a tile of N vectors, then drains the skew pipeline with zeros and signals completion.

Parameters:
- MUL_DATAWIDTH, 8, width of one activation element
- NUM_ROWS, 4, number of array rows (skew depth is NUM_ROWS-1); must be >= 1
- CNT_WIDTH, 16, width of the vector count and internal counters

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- i_start  input  1  single-cycle pulse that begins a tile; sampled only in IDLE
- i_num_vecs  input  CNT_WIDTH  number of vectors in the tile; latched on an accepted i_start
- i_act_vec  input  MUL_DATAWIDTH x NUM_ROWS  unskewed activation vector
- i_act_valid  input  1  i_act_vec holds valid data
- o_act_ready  output  1  block accepts i_act_vec this cycle
- o_act  output  MUL_DATAWIDTH x NUM_ROWS  skewed activations to the array
- o_act_vld  output  NUM_ROWS  per-row flag: o_act[r] carries real data, not bubble or drain zero
- o_busy  output  1  high in STREAM and DRAIN
- o_done  output  1  single-cycle pulse when the tile has fully left the skew pipeline

Behaviour:
- Reset: all skew registers, counters and o_act_vld are cleared; state becomes IDLE.
  - Outputs after reset: o_act = 0, o_act_vld = 0, o_act_ready = 0, o_busy = 0, o_done = 0.
  - Reset mid-tile abandons the tile immediately; no o_done is produced.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - i_start with i_num_vecs > 0: latch the count, go to STREAM.
  - i_start with i_num_vecs == 0: go to DONE.
  - Otherwise stay in IDLE.
- STREAM:
  - o_act_ready = 1.
  - A transfer occurs when i_act_valid && o_act_ready; each transfer increments the accepted count.
  - On the transfer that makes the count reach the latched N, go to DRAIN next cycle.
- DRAIN:
  - Lasts exactly NUM_ROWS-1 cycles, tracked by a drain counter; zeros are injected.
  - With NUM_ROWS == 1, DRAIN lasts 0 cycles: STREAM goes directly to DONE.
- DONE: o_done = 1 for one cycle, then return to IDLE.
- i_start outside IDLE is ignored.
- Skew pipeline:
  - The pipeline shifts every cycle in every state; the block never stalls the array.
  - Row r is a chain of r+1 registers.
  - A vector accepted at edge t appears with element r on o_act[r] during cycle t+1+r.
  - o_act_vld[r] follows the same delay.
- Bubbles: a STREAM cycle with no transfer injects 0 with vld = 0 into every row; the count does not advance.
  - Downstream therefore sees zero activations, which contribute nothing to psums.
- Outside STREAM, zeros with vld = 0 are injected.
- DRAIN length guarantees the last vector's row NUM_ROWS-1 element has been presented before o_done.
  - o_done is asserted in the cycle after that element is presented.
- No combinational path from any input to any output; o_act_ready depends only on state.
- Counters do not wrap: the count stops at N because o_act_ready drops after the final transfer.

Optional Feature:
- Macro: SA_SKEW_BUBBLE_CNT_EN.
- Defined:
  - Adds output o_bubble_cnt, width CNT_WIDTH.
  - Counts STREAM cycles with o_act_ready = 1 and i_act_valid = 0.
  - Saturates at all-ones; cleared by rst and by an accepted i_start.
  - Holds its value after o_done until the next accepted i_start.
- Not defined: the port and its counter do not exist; all other behaviour is identical.

Test Plan (NUM_ROWS = 4, MUL_DATAWIDTH = 8):
- Reset, then idle for 10 cycles -> o_act all 0, o_act_vld = 0000, o_busy = 0, o_done never asserted.
- Start N = 2, back-to-back vectors {1,2,3,4} then {5,6,7,8}, first accepted at edge t:
  - o_act[0] = 1 at t+1 and 5 at t+2.
  - o_act[3] = 4 at t+4 and 8 at t+5.
  - o_done pulses at t+6; o_busy covers t+1..t+5.
- Start N = 3 with i_act_valid low for 2 cycles between the 1st and 2nd vector:
  - Two zero, vld = 0 diagonals appear between the real diagonals.
  - o_done is delayed by exactly 2 cycles versus the back-to-back case.
  - With SA_SKEW_BUBBLE_CNT_EN defined, o_bubble_cnt = 2.
- Start N = 0 -> o_done pulses the cycle after the start; o_act_ready is never 1; o_act_vld stays 0000.
- Assert i_start during STREAM of an N = 4 tile -> ignored; exactly 4 transfers, then one o_done.
- Assert rst after 2 of 4 vectors are accepted:
  - Next cycle o_act = 0 and o_act_vld = 0000, state IDLE, no o_done.
  - A new start with N = 1 then completes normally.

Source files
------------

// File: rtl/sa_act_skew.sv
// sa_act_skew -- input-activation skew stage for a weight-stationary array.
//
// Accepts one unskewed activation vector per cycle (one element per array
// row) over a valid/ready handshake. It delays row r by r cycles, so the
// array receives a diagonal wavefront. Each tile of N vectors is followed by
// NUM_ROWS-1 drain cycles of zeros. o_done then marks completion.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_start       begins a tile (sampled only in IDLE)
//   i_num_vecs    vectors in the tile, latched with an accepted i_start
//   i_act_vec     unskewed activation vector, element r for row r
//   i_act_valid   i_act_vec holds valid data
//   o_act_ready   vector accepted this cycle (high only while streaming)
//   o_act         skewed activations to the array
//   o_act_vld     per-row flag: o_act[r] carries real data
//   o_busy        tile in progress (aligned with the skewed output stream)
//   o_done        one-cycle pulse after the last element has left the skew
//   o_bubble_cnt  (only with SA_SKEW_BUBBLE_CNT_EN) saturating count of
//                 streaming cycles with no valid input
//
// Optional feature macro: SA_SKEW_BUBBLE_CNT_EN.

module sa_act_skew #(
  parameter int MUL_DATAWIDTH = 8,
  parameter int NUM_ROWS      = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_start,
  input  logic [CNT_WIDTH-1:0]                    i_num_vecs,
  input  logic [NUM_ROWS-1:0][MUL_DATAWIDTH-1:0]  i_act_vec,
  input  logic                                    i_act_valid,
  output logic                                    o_act_ready,
  output logic [NUM_ROWS-1:0][MUL_DATAWIDTH-1:0]  o_act,
  output logic [NUM_ROWS-1:0]                     o_act_vld,
  output logic                                    o_busy,
  output logic                                    o_done
`ifdef SA_SKEW_BUBBLE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]                    o_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // With a single row there is nothing to drain.
  localparam logic HAS_DRAIN = (NUM_ROWS > 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(NUM_ROWS - 2);

  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   count_reg, count_inc;
  logic [CNT_WIDTH-1:0]   num_reg;
  logic [CNT_WIDTH-1:0]   drain_reg;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   xfer;
  logic                   start_acc;
  logic                   last_xfer;

  assign xfer      = i_act_valid & o_act_ready;
  assign start_acc = (state_reg == ST_IDLE) & i_start;
  assign count_inc = count_reg + CNT_WIDTH'(1);
  assign last_xfer = xfer & (count_inc == num_reg);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next = (i_num_vecs == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_xfer) begin
          state_next = HAS_DRAIN ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // o_busy and o_done go through one register so that they line up with the
  // skewed data. o_done then lands one cycle after the last row's final
  // element.
  always_comb begin
    o_act_ready = (state_reg == ST_STREAM);
    busy_next   = (state_reg == ST_STREAM) | (state_reg == ST_DRAIN);
    done_next   = (state_reg == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  assign o_busy = busy_reg;
  assign o_done = done_reg;

  // ---------------- Tile counters ----------------
  // The count cannot pass num_reg: ready drops after the final transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      num_reg   <= '0;
      drain_reg <= '0;
    end else begin
      if (start_acc) begin
        num_reg   <= i_num_vecs;
        count_reg <= '0;
      end else if (xfer) begin
        count_reg <= count_inc;
      end

      if (state_reg == ST_DRAIN) begin
        drain_reg <= drain_reg + CNT_WIDTH'(1);
      end else begin
        drain_reg <= '0;
      end
    end
  end

`ifdef SA_SKEW_BUBBLE_CNT_EN
  logic [CNT_WIDTH-1:0] bubble_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_reg <= '0;
    end else if (start_acc) begin
      bubble_reg <= '0;
    end else if (o_act_ready && !i_act_valid && (bubble_reg != '1)) begin
      bubble_reg <= bubble_reg + CNT_WIDTH'(1);
    end
  end

  assign o_bubble_cnt = bubble_reg;
`endif

  // ---------------- Skew pipeline ----------------
  // Row gi is a shift chain of gi+1 registers that advances every cycle.
  // A cycle with no transfer inserts a zero with vld low. Bubbles and drain
  // cycles therefore add nothing to downstream partial sums.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      logic [MUL_DATAWIDTH-1:0] data_reg [0:gi];
      logic                     vld_reg  [0:gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k <= gi; k++) begin
            data_reg[k] <= '0;
            vld_reg[k]  <= 1'b0;
          end
        end else begin
          data_reg[0] <= xfer ? i_act_vec[gi] : '0;
          vld_reg[0]  <= xfer;
          for (int k = 1; k <= gi; k++) begin
            data_reg[k] <= data_reg[k-1];
            vld_reg[k]  <= vld_reg[k-1];
          end
        end
      end

      assign o_act[gi]     = data_reg[gi];
      assign o_act_vld[gi] = vld_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_sa_act_skew.sv
// Directed testbench for sa_act_skew (NUM_ROWS = 4, MUL_DATAWIDTH = 8).
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// at the same point, which is away from the active edge.

module tb_sa_act_skew;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int CW = 16;

  logic                 clk;
  logic                 rst;
  logic                 i_start;
  logic [CW-1:0]        i_num_vecs;
  logic [NR-1:0][DW-1:0] i_act_vec;
  logic                 i_act_valid;
  logic                 o_act_ready;
  logic [NR-1:0][DW-1:0] o_act;
  logic [NR-1:0]        o_act_vld;
  logic                 o_busy;
  logic                 o_done;
`ifdef SA_SKEW_BUBBLE_CNT_EN
  logic [CW-1:0]        o_bubble_cnt;
`endif

  sa_act_skew #(
    .MUL_DATAWIDTH(DW),
    .NUM_ROWS(NR),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_num_vecs(i_num_vecs),
    .i_act_vec(i_act_vec),
    .i_act_valid(i_act_valid),
    .o_act_ready(o_act_ready),
    .o_act(o_act),
    .o_act_vld(o_act_vld),
    .o_busy(o_busy),
    .o_done(o_done)
`ifdef SA_SKEW_BUBBLE_CNT_EN
    ,
    .o_bubble_cnt(o_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Capture window: index k is sampled just after the k-th edge of the tile
  logic [31:0] vec_tab  [0:15];
  logic [31:0] cap_act  [0:15];
  logic [3:0]  cap_vld  [0:15];
  logic        cap_done [0:15];
  logic        cap_busy [0:15];
  logic        cap_xfer [0:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] row(input logic [31:0] w, input int r);
    return 32'(w[8*r +: 8]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input int n);
    i_start    = 1'b1;
    i_num_vecs = CW'(n);
    tick();
    i_start    = 1'b0;
  endtask

  // Drives 16 cycles. valid comes from vmask, data from vec_tab, and an
  // optional i_start pulse is applied at cycle start_at.
  task automatic run_capture(input logic [15:0] vmask, input int start_at);
    for (int k = 0; k < 16; k++) begin
      i_act_valid = vmask[k];
      i_act_vec   = vec_tab[k];
      i_start     = (k == start_at);
      i_num_vecs  = CW'(9);
      cap_xfer[k] = i_act_valid & o_act_ready;
      tick();
      cap_act[k]  = o_act;
      cap_vld[k]  = o_act_vld;
      cap_done[k] = o_done;
      cap_busy[k] = o_busy;
    end
    i_act_valid = 1'b0;
    i_start     = 1'b0;
  endtask

  function automatic int done_count();
    int c = 0;
    for (int k = 0; k < 16; k++) c += int'(cap_done[k]);
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst         = 1'b1;
    i_start     = 1'b0;
    i_num_vecs  = '0;
    i_act_vec   = '0;
    i_act_valid = 1'b0;
    for (int k = 0; k < 16; k++) vec_tab[k] = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // ---- Reset state and 10 idle cycles ----
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_act", o_act, 32'h0);
      check("idle_vld", 32'(o_act_vld), 32'h0);
      check("idle_busy", 32'(o_busy), 32'h0);
      check("idle_done", 32'(o_done), 32'h0);
      check("idle_ready", 32'(o_act_ready), 32'h0);
    end
`ifdef SA_SKEW_BUBBLE_CNT_EN
    check("idle_bubble", 32'(o_bubble_cnt), 32'h0);
`endif
    $display("reset/idle: done");

    // ---- N = 2 back-to-back ----
    for (int k = 0; k < 16; k++) vec_tab[k] = 32'hAAAAAAAA;
    vec_tab[0] = 32'h04030201;
    vec_tab[1] = 32'h08070605;
    start_tile(2);
    check("n2_ready", 32'(o_act_ready), 32'h1);
    check("n2_busy_pre", 32'(o_busy), 32'h0);
    run_capture(16'h0003, -1);
    check("n2_row0_k0", row(cap_act[0], 0), 32'h01);
    check("n2_row0_k1", row(cap_act[1], 0), 32'h05);
    check("n2_row0_k2", row(cap_act[2], 0), 32'h00);
    check("n2_row1_k1", row(cap_act[1], 1), 32'h02);
    check("n2_row3_k3", row(cap_act[3], 3), 32'h04);
    check("n2_row3_k4", row(cap_act[4], 3), 32'h08);
    check("n2_row3_k5", row(cap_act[5], 3), 32'h00);
    check("n2_vld_k0", 32'(cap_vld[0]), 32'h1);
    check("n2_vld_k3", 32'(cap_vld[3]), 32'hC);
    check("n2_vld_k4", 32'(cap_vld[4]), 32'h8);
    for (int k = 0; k < 6; k++) check($sformatf("n2_busy_k%0d", k), 32'(cap_busy[k]), (k < 5) ? 32'h1 : 32'h0);
    check("n2_done_k5", 32'(cap_done[5]), 32'h1);
    check("n2_done_cnt", 32'(done_count()), 32'h1);
`ifdef SA_SKEW_BUBBLE_CNT_EN
    check("n2_bubble", 32'(o_bubble_cnt), 32'h0);
`endif
    $display("tile N=2 back-to-back: done");

    // ---- N = 3 with two bubbles after the first vector ----
    for (int k = 0; k < 16; k++) vec_tab[k] = 32'hEEEEEEEE;
    vec_tab[0] = 32'h14131211;
    vec_tab[3] = 32'h24232221;
    vec_tab[4] = 32'h34333231;
    start_tile(3);
    run_capture(16'h0019, -1);
    check("n3_row0_k0", row(cap_act[0], 0), 32'h11);
    check("n3_row0_k1", row(cap_act[1], 0), 32'h00);
    check("n3_row0_k2", row(cap_act[2], 0), 32'h00);
    check("n3_row0_k3", row(cap_act[3], 0), 32'h21);
    check("n3_row0_k4", row(cap_act[4], 0), 32'h31);
    check("n3_vld_k1", 32'(cap_vld[1]), 32'h2);
    check("n3_vld_k2", 32'(cap_vld[2]), 32'h4);
    check("n3_row3_k3", row(cap_act[3], 3), 32'h14);
    check("n3_row3_k4", row(cap_act[4], 3), 32'h00);
    check("n3_row3_k5", row(cap_act[5], 3), 32'h00);
    check("n3_row3_k6", row(cap_act[6], 3), 32'h24);
    check("n3_row3_k7", row(cap_act[7], 3), 32'h34);
    check("n3_vld_k4", 32'(cap_vld[4]), 32'h3);
    check("n3_vld_k5", 32'(cap_vld[5]), 32'h6);
    check("n3_done_k8", 32'(cap_done[8]), 32'h1);
    check("n3_done_cnt", 32'(done_count()), 32'h1);
`ifdef SA_SKEW_BUBBLE_CNT_EN
    check("n3_bubble", 32'(o_bubble_cnt), 32'h2);
`endif
    $display("tile N=3 with 2 bubbles: done");

    // ---- N = 0 ----
    for (int k = 0; k < 16; k++) vec_tab[k] = 32'h55555555;
    start_tile(0);
    check("n0_ready", 32'(o_act_ready), 32'h0);
    run_capture(16'hFFFF, -1);
    check("n0_done_k0", 32'(cap_done[0]), 32'h1);
    check("n0_done_cnt", 32'(done_count()), 32'h1);
    c = 0;
    for (int k = 0; k < 16; k++) c += int'(cap_xfer[k]) + int'(cap_vld[k] != 4'h0);
    check("n0_no_xfer_vld", 32'(c), 32'h0);
`ifdef SA_SKEW_BUBBLE_CNT_EN
    check("n0_bubble", 32'(o_bubble_cnt), 32'h0);
`endif
    $display("tile N=0: done");

    // ---- N = 4 with i_start during STREAM (ignored) ----
    for (int k = 0; k < 16; k++) vec_tab[k] = 32'h40404040 + 32'(k);
    start_tile(4);
    run_capture(16'hFFFF, 1);
    c = 0;
    for (int k = 0; k < 16; k++) c += int'(cap_xfer[k]);
    check("n4_xfers", 32'(c), 32'h4);
    check("n4_last_xfer_k3", 32'(cap_xfer[3]), 32'h1);
    check("n4_row0_k3", row(cap_act[3], 0), 32'h43);
    check("n4_row3_k6", row(cap_act[6], 3), 32'h40);
    check("n4_done_k7", 32'(cap_done[7]), 32'h1);
    check("n4_done_cnt", 32'(done_count()), 32'h1);
`ifdef SA_SKEW_BUBBLE_CNT_EN
    check("n4_bubble", 32'(o_bubble_cnt), 32'h0);
`endif
    $display("tile N=4 with ignored start: done");

    // ---- Reset after 2 of 4 vectors ----
    start_tile(4);
    i_act_valid = 1'b1;
    i_act_vec   = 32'h67666564;
    tick();
    tick();
    rst         = 1'b1;
    i_act_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_act", o_act, 32'h0);
    check("rst_vld", 32'(o_act_vld), 32'h0);
    check("rst_ready", 32'(o_act_ready), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    c = int'(o_done);
    for (int i = 0; i < 8; i++) begin
      tick();
      c += int'(o_done);
    end
    check("rst_no_done", 32'(c), 32'h0);
    check("rst_ready_idle", 32'(o_act_ready), 32'h0);

    for (int k = 0; k < 16; k++) vec_tab[k] = 32'h99999999;
    vec_tab[0] = 32'h0D0C0B0A;
    start_tile(1);
    run_capture(16'h0001, -1);
    check("n1_row0_k0", row(cap_act[0], 0), 32'h0A);
    check("n1_row3_k3", row(cap_act[3], 3), 32'h0D);
    check("n1_vld_k3", 32'(cap_vld[3]), 32'h8);
    check("n1_done_k4", 32'(cap_done[4]), 32'h1);
    check("n1_done_cnt", 32'(done_count()), 32'h1);
    $display("reset mid-tile then N=1: done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
